// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte width, FIFO depth, header layout.
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  // Header byte layout: destination in [1:0], payload length in [7:2].
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_LEN_MSB  = 7;

  localparam int unsigned PKT_CNT_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {
    DestAddr0   = 2'b00,
    DestAddr1   = 2'b01,
    DestAddr2   = 2'b10,
    DestInvalid = 2'b11
  } dest_addr_e;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_len(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB] + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Flop-based storage for the router output FIFO: one synchronous write port,
// one combinational read port, no reset on the array.
module router_fifo_mem #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_fifo_buf.sv
// Per-destination output FIFO of the 1x3 router. Stores each byte with a header
// tag and tracks remaining packet length on the read side.
module router_fifo_buf #(
  parameter int unsigned DATA_W = router_pkg::DATA_W,
  parameter int unsigned DEPTH  = router_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_busy
);

  import router_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]        data_out_q, data_out_d;
  logic [PKT_CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic                     pkt_busy_q, pkt_busy_d;
  logic [DATA_W:0]          rd_word;
  logic                     wr_accept, rd_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A flush discards any request in the same cycle, including the memory write.
  assign wr_accept = write_enb && !full && !soft_reset;
  assign rd_accept = read_enb && !empty && !soft_reset;

  router_fifo_mem #(
    .Width (DATA_W + 1),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[PTR_W-1:0]),
    .wdata_i ({lfd_state, data_in}),
    .raddr_i (rd_ptr_q[PTR_W-1:0]),
    .rdata_o (rd_word)
  );

  // Next-state: pointer advance, read data capture and packet length tracking.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      pkt_cnt_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      end
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + (PTR_W + 1)'(1);
        data_out_d = rd_word[DATA_W-1:0];
        if (rd_word[DATA_W]) begin
          pkt_cnt_d = hdr_pkt_len(rd_word[DATA_W-1:0]);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
        end
        // A stray untagged byte with no packet open leaves the count at zero.
      end
    end
    pkt_busy_d = (pkt_cnt_d != '0);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      pkt_cnt_q  <= '0;
      pkt_busy_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_busy_q <= pkt_busy_d;
    end
  end

  assign data_out = data_out_q;
  assign pkt_busy = pkt_busy_q;

endmodule

// File: tb/tb_router_fifo_buf.sv
// Scoreboard bench for router_fifo_buf: the driver keeps a reference FIFO model and
// pushes the expected post-edge state; a negedge monitor pops and compares.
module tb_router_fifo_buf;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;

  logic          clock;
  logic          resetn;
  logic          soft_reset;
  logic          write_enb;
  logic          read_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          pkt_busy;

  router_fifo_buf #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .pkt_busy   (pkt_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic          busy;
    logic          full;
    logic          empty;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW:0]   model_q[$];
  logic [5:0]    pkt_m;
  logic [DW-1:0] dout_m;
  int            n_checks = 0;
  int            n_err    = 0;

  task automatic chk(input string nm, input string fld, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "data_out", data_out, e.data);
      chk(e.name, "pkt_busy", {7'd0, pkt_busy}, {7'd0, e.busy});
      chk(e.name, "full", {7'd0, full}, {7'd0, e.full});
      chk(e.name, "empty", {7'd0, empty}, {7'd0, e.empty});
    end
  end

  task automatic step(input logic we, input logic re, input logic lfd, input logic sr,
                      input logic [DW-1:0] din, input string name);
    logic        wr_ok;
    logic        rd_ok;
    logic [DW:0] item;
    exp_t        e;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    soft_reset = sr;
    data_in    = din;
    wr_ok = we && (model_q.size() < DP) && !sr;
    rd_ok = re && (model_q.size() != 0) && !sr;
    @(posedge clock);
    #1;
    if (sr) begin
      model_q.delete();
      pkt_m  = '0;
      dout_m = '0;
    end else begin
      if (rd_ok) begin
        item   = model_q.pop_front();
        dout_m = item[DW-1:0];
        if (item[DW]) pkt_m = item[7:2] + 6'd1;
        else if (pkt_m != 0) pkt_m = pkt_m - 6'd1;
      end
      if (wr_ok) model_q.push_back({lfd, din});
    end
    e.name  = name;
    e.data  = dout_m;
    e.busy  = (pkt_m != 0);
    e.full  = (model_q.size() == DP);
    e.empty = (model_q.size() == 0);
    exp_q.push_back(e);
  endtask

  initial begin
    logic [DW-1:0] pkt_bytes [5];
    pkt_bytes[0] = 8'h0C; pkt_bytes[1] = 8'h11; pkt_bytes[2] = 8'h22;
    pkt_bytes[3] = 8'h33; pkt_bytes[4] = 8'hAA;
    pkt_m      = '0;
    dout_m     = '0;
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    // 1 reset state
    step(0, 0, 0, 0, 8'h00, "reset");

    // 2 one packet: header length 3 -> four more bytes after the header
    for (int i = 0; i < 5; i++) step(1, 0, (i == 0), 0, pkt_bytes[i], "pkt_wr");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00, "pkt_rd");
    step(0, 0, 0, 0, 8'h00, "pkt_hold");

    // 3 fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h40 + i), "fill_wr");
    step(1, 0, 0, 0, 8'hFF, "fill_overflow");
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00, "fill_rd");
    step(0, 1, 0, 0, 8'h00, "empty_rd");

    // 4 full with simultaneous write and read
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h80 + i), "full2_wr");
    step(1, 1, 0, 0, 8'h77, "full_wr_rd");
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 8'h00, "full2_rd");

    // 5 soft reset overriding a write, then a read that must be ignored
    step(1, 0, 1, 0, 8'h08, "sr_wr");
    step(0, 1, 0, 0, 8'h00, "sr_rd");
    step(1, 0, 0, 0, 8'h55, "sr_wr");
    step(1, 0, 0, 1, 8'h66, "soft_reset");
    step(0, 1, 0, 0, 8'h00, "sr_after_rd");

    // 6 streaming across pointer wraps
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 8'(i * 7 + 3), "stream");
    step(0, 1, 0, 0, 8'h00, "stream_last");
    step(0, 0, 0, 0, 8'h00, "idle");

    repeat (2) @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
